// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU and its fetch unit: opcodes, the
// fetch-state encoding and the layout of the 24-bit program word.
package cpu_pkg;

   localparam logic [7:0] OP_AND   = 8'h00;
   localparam logic [7:0] OP_OR    = 8'h01;
   localparam logic [7:0] OP_ADD   = 8'h02;
   localparam logic [7:0] OP_SUB   = 8'h03;
   localparam logic [7:0] OP_LD    = 8'h04;
   localparam logic [7:0] OP_STORE = 8'h05;
   localparam logic [7:0] OP_JMP   = 8'h06;
   localparam logic [7:0] OP_HALT  = 8'hFF;

   localparam int WORD_W  = 24;
   localparam int FIELD_W = 8;
   localparam int OP_LSB  = 16;
   localparam int A_LSB   = 8;
   localparam int B_LSB   = 0;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      DECODE,
      ISSUE,
      HALTED
   } fetch_state_e;

endpackage

// File: rtl/cpu_prog_mem.sv
// Program memory: one synchronous write port, one registered read port.
// Contents are deliberately not reset so the array maps onto block RAM.
module cpu_prog_mem
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data
);

   localparam int DEPTH = 1 << ADDR_W;

   logic [WORD_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[wr_addr] <= wr_data;
      end
      rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/cpu_fetch_unit.sv
// Instruction sequencer: steps the PC through program memory, resolves JMP
// and HALT locally and hands every other word to the CPU over valid/ready.
module cpu_fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              prog_we,
   input  logic [ADDR_W-1:0] prog_addr,
   input  logic [23:0]       prog_data,
   input  logic              issue_ready,
   output logic              issue_valid,
   output logic [7:0]        instruction,
   output logic [7:0]        data_in_a,
   output logic [7:0]        data_in_b,
   output logic [ADDR_W-1:0] pc,
   output logic              halted
);

   fetch_state_e        state;
   logic [WORD_W-1:0]   rd_data;
   logic                mem_we;
   logic [FIELD_W-1:0]  word_op;
   logic [FIELD_W-1:0]  word_a;
   logic [FIELD_W-1:0]  word_b;

   // The program may only be rewritten while nothing is executing.
   assign mem_we  = prog_we && ((state == IDLE) || (state == HALTED));
   assign word_op = rd_data[OP_LSB +: FIELD_W];
   assign word_a  = rd_data[A_LSB  +: FIELD_W];
   assign word_b  = rd_data[B_LSB  +: FIELD_W];

   cpu_prog_mem #(
      .ADDR_W (ADDR_W)
   ) u_prog_mem (
      .clk     (clk),
      .we      (mem_we),
      .wr_addr (prog_addr),
      .wr_data (prog_data),
      .rd_addr (pc),
      .rd_data (rd_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         pc          <= '0;
         issue_valid <= 1'b0;
         instruction <= '0;
         data_in_a   <= '0;
         data_in_b   <= '0;
         halted      <= 1'b0;
      end else begin
         case (state)
            IDLE, HALTED: begin
               if (start) begin
                  state  <= FETCH;
                  pc     <= '0;
                  halted <= 1'b0;
               end
            end
            FETCH: begin
               state <= DECODE;
            end
            DECODE: begin
               // rd_data holds the word addressed by pc during FETCH.
               if (word_op == OP_JMP) begin
                  pc    <= word_a[ADDR_W-1:0];
                  state <= FETCH;
               end else if (word_op == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= HALTED;
               end else begin
                  instruction <= word_op;
                  data_in_a   <= word_a;
                  data_in_b   <= word_b;
                  issue_valid <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_ready) begin
                  issue_valid <= 1'b0;
                  pc          <= pc + 1'b1;
                  state       <= FETCH;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_fetch_unit.sv
// Self-checking bench for cpu_fetch_unit: a program-level model predicts the
// issue stream, a negedge monitor compares every valid cycle against it.
module tb_cpu_fetch_unit;

   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic          prog_we;
   logic [AW-1:0] prog_addr;
   logic [23:0]   prog_data;
   logic          issue_ready;
   logic          issue_valid;
   logic [7:0]    instruction;
   logic [7:0]    data_in_a;
   logic [7:0]    data_in_b;
   logic [AW-1:0] pc;
   logic          halted;

   cpu_fetch_unit #(.ADDR_W(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .prog_we     (prog_we),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .issue_ready (issue_ready),
      .issue_valid (issue_valid),
      .instruction (instruction),
      .data_in_a   (data_in_a),
      .data_in_b   (data_in_b),
      .pc          (pc),
      .halted      (halted)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0]    op;
      logic [7:0]    a;
      logic [7:0]    b;
      logic [AW-1:0] pc;
   } exp_t;

   int            errors = 0;
   int            checks = 0;
   int            cyc = 0;
   logic [23:0]   tb_mem [16];
   exp_t          exp_q [$];
   int            xfer_cyc [$];
   logic [AW-1:0] model_halt_pc;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Program-level model: walk the program from address 0 as the CPU would see it.
   task automatic build_model(input int max_issues);
      logic [AW-1:0] mpc;
      logic [23:0]   w;
      exp_t          e;
      exp_q.delete();
      mpc = '0;
      model_halt_pc = '0;
      for (int step = 0; step < 400; step++) begin
         w = tb_mem[mpc];
         if (w[23:16] == 8'h06) begin
            mpc = w[8 +: AW];
         end else if (w[23:16] == 8'hFF) begin
            model_halt_pc = mpc;
            break;
         end else begin
            e.op = w[23:16];
            e.a  = w[15:8];
            e.b  = w[7:0];
            e.pc = mpc;
            exp_q.push_back(e);
            if (exp_q.size() >= max_issues) break;
            mpc = mpc + 1'b1;
         end
      end
   endtask

   // Monitor: every valid cycle must show the oldest unconsumed model entry.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         exp_q.delete();
      end else if (issue_valid) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_issue", {instruction, data_in_a, data_in_b, 4'(pc)}, 32'hFFFF_FFFF);
         end else begin
            chk("issue", {4'h0, instruction, data_in_a, data_in_b, pc}, {4'h0, exp_q[0]});
         end
         if (issue_ready) begin
            xfer_cyc.push_back(cyc);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
         end
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic prog_write(input logic [AW-1:0] addr, input logic [23:0] data, input bit honoured);
      prog_we   = 1'b1;
      prog_addr = addr;
      prog_data = data;
      tick();
      prog_we = 1'b0;
      if (honoured) tb_mem[addr] = data;
   endtask

   task automatic pulse_start(output int s_cyc);
      start = 1'b1;
      tick();
      start = 1'b0;
      s_cyc = cyc;
   endtask

   task automatic wait_xfers(input int n, input int budget);
      int k = 0;
      while (xfer_cyc.size() < n && k < budget) begin
         tick();
         k++;
      end
      chk("xfer_timeout", 32'(xfer_cyc.size() >= n), 32'd1);
   endtask

   task automatic wait_halted(input int budget);
      int k = 0;
      while (halted !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      chk("halt_timeout", 32'(halted), 32'd1);
   endtask

   task automatic wait_valid(input int budget);
      int k = 0;
      while (issue_valid !== 1'b1 && k < budget) begin
         tick();
         k++;
      end
      chk("valid_timeout", 32'(issue_valid), 32'd1);
   endtask

   initial begin
      int s;
      int base;
      logic [23:0] snap;
      logic [AW-1:0] snap_pc;

      for (int i = 0; i < 16; i++) tb_mem[i] = 24'h0;
      reset = 1'b0; start = 1'b0; prog_we = 1'b0; prog_addr = '0;
      prog_data = '0; issue_ready = 1'b0;

      // Reset held: a start pulse must not wake the block.
      tick(); tick();
      start = 1'b1; tick(); start = 1'b0; tick();
      chk("rst_valid", 32'(issue_valid), 32'd0);
      chk("rst_fields", {8'h0, instruction, data_in_a, data_in_b}, 32'h0);
      chk("rst_pc", 32'(pc), 32'd0);
      chk("rst_halted", 32'(halted), 32'd0);
      reset = 1'b1;
      tick();

      // Straight-line program.
      prog_write(4'd0, 24'h020503, 1'b1);
      prog_write(4'd1, 24'h030F01, 1'b1);
      prog_write(4'd2, 24'hFF0000, 1'b1);
      build_model(100);
      chk("model_straight_n", 32'(exp_q.size()), 32'd2);
      chk("model_straight_0", {4'h0, exp_q[0]}, 32'h0020_5030);
      chk("model_straight_1", {4'h0, exp_q[1]}, 32'h0030_F011);
      issue_ready = 1'b1;
      base = xfer_cyc.size();
      pulse_start(s);
      wait_xfers(base + 2, 20);
      wait_halted(20);
      chk("straight_lat", 32'(xfer_cyc[base] - s), 32'd2);
      chk("straight_gap", 32'(xfer_cyc[base+1] - xfer_cyc[base]), 32'd3);
      chk("straight_halt_pc", 32'(pc), 32'd2);
      chk("straight_left", 32'(exp_q.size()), 32'd0);

      // Jump over addresses 1..2.
      prog_write(4'd0, 24'h060300, 1'b1);
      prog_write(4'd3, 24'h00CCAA, 1'b1);
      prog_write(4'd4, 24'hFF0000, 1'b1);
      build_model(100);
      chk("model_jump_0", {4'h0, exp_q[0]}, 32'h000C_CAA3);
      base = xfer_cyc.size();
      pulse_start(s);
      wait_xfers(base + 1, 20);
      wait_halted(20);
      chk("jump_lat", 32'(xfer_cyc[base] - s), 32'd4);
      chk("jump_halt_pc", 32'(pc), 32'd4);
      chk("jump_halted", 32'(halted), 32'd1);

      // Start together with a write in HALTED; backpressure on the first issue.
      issue_ready = 1'b0;
      tb_mem[0] = 24'h011122;
      build_model(100);
      chk("model_bp_0", {4'h0, exp_q[0]}, 32'h0011_1220);
      base = xfer_cyc.size();
      prog_we = 1'b1; prog_addr = 4'd0; prog_data = 24'h011122;
      pulse_start(s);
      prog_we = 1'b0;
      chk("bp_halted_clr", 32'(halted), 32'd0);
      wait_valid(10);
      snap = {instruction, data_in_a, data_in_b};
      snap_pc = pc;
      chk("bp_first", {8'h0, snap}, 32'h0001_1122);
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("bp_hold", {4'h0, 1'b0, issue_valid, instruction, data_in_a, data_in_b, 2'b0},
             {4'h0, 1'b0, 1'b1, snap, 2'b0});
         chk("bp_pc_hold", 32'(pc), 32'(snap_pc));
      end
      issue_ready = 1'b1;
      tick();
      issue_ready = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("bp_one_xfer", 32'(xfer_cyc.size() - base), 32'd1);
      chk("bp_next_op", 32'(instruction), 32'h03);
      issue_ready = 1'b1;
      wait_halted(20);
      chk("bp_halt_pc", 32'(pc), 32'd2);

      // Wrap: every word is ADD, execution runs past address 15.
      for (int i = 0; i < 16; i++) prog_write(4'(i), {8'h02, 8'(i), 8'(i) ^ 8'hFF}, 1'b1);
      build_model(40);
      chk("model_wrap_16", 32'(exp_q[16].pc), 32'd0);
      base = xfer_cyc.size();
      pulse_start(s);
      wait_xfers(base + 20, 100);

      // Write lockout during ISSUE, then asynchronous reset mid-issue.
      issue_ready = 1'b0;
      wait_valid(10);
      prog_write(4'd1, 24'h05ABCD, 1'b0);
      chk("lock_valid", 32'(issue_valid), 32'd1);
      #2 reset = 1'b0;
      #1;
      chk("async_valid", 32'(issue_valid), 32'd0);
      chk("async_pc", 32'(pc), 32'd0);
      #3 reset = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      chk("post_rst_idle", {30'h0, issue_valid, halted}, 32'h0);
      chk("post_rst_pc", 32'(pc), 32'd0);

      // Re-read: address 1 must still hold its ADD word.
      issue_ready = 1'b1;
      build_model(40);
      chk("model_reread_1", {4'h0, exp_q[1]}, 32'h0020_1FE1);
      base = xfer_cyc.size();
      pulse_start(s);
      wait_xfers(base + 2, 20);
      reset = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/cpu_fetch_unit.md
# cpu_fetch_unit

Instruction sequencer directly upstream of the `CPU` datapath. Holds a small program memory of 24-bit words, steps a program counter and issues each word as `instruction` / `data_in_a` / `data_in_b` to the CPU over a valid/ready handshake. It resolves `JMP` and `HALT` locally.

## Interface

Parameters:
- `ADDR_W`, 4: program-counter and memory address width; the memory depth is 2^ADDR_W words.

Ports:
- `clk`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low. `reset` = 0 resets the block.
- `start`  input  1  one-cycle pulse that starts execution from PC 0. It is honoured only in IDLE or HALTED.
- `prog_we`  input  1  program-memory write strobe. It is honoured only in IDLE or HALTED.
- `prog_addr`  input  ADDR_W  program-memory write address.
- `prog_data`  input  24  program word, laid out as {opcode[23:16], a[15:8], b[7:0]}.
- `issue_ready`  input  1  the CPU accepts the current issue.
- `issue_valid`  output  1  `instruction`, `data_in_a` and `data_in_b` are valid.
- `instruction`  output  8  opcode presented to the CPU.
- `data_in_a`  output  8  operand A.
- `data_in_b`  output  8  operand B.
- `pc`  output  ADDR_W  current program counter.
- `halted`  output  1  high while in HALTED.

## Operation

- Opcodes 0x00–0x05 (AND, OR, ADD, SUB, LD, STORE) are issued to the CPU unchanged.
- 0x06 JMP:
  - sets `pc` to `a[ADDR_W-1:0]`;
  - is not issued to the CPU.
- 0xFF HALT:
  - enters HALTED;
  - is not issued.
- Other opcodes are issued unchanged; the CPU owns illegal-opcode handling.
- FSM states:
  - IDLE: reset state. `start` → FETCH with `pc` = 0.
  - FETCH: drives the memory read address = `pc`. Next state is DECODE.
  - DECODE: the memory word is valid.
    - JMP → `pc` = target, then FETCH.
    - HALT → HALTED; `pc` holds the HALT address.
    - Otherwise, register the three fields into the outputs, then ISSUE.
  - ISSUE: `issue_valid` = 1. Outputs are held stable until `issue_ready` = 1.
    - On handshake, `pc` = `pc` + 1 (mod 2^ADDR_W), then FETCH.
  - HALTED: `halted` = 1. `start` → FETCH with `pc` = 0.
- PC wrap: after the issue at address 2^ADDR_W − 1, `pc` wraps to 0. There is no error.
- A JMP whose target is its own address is a legal infinite loop: FETCH/DECODE repeat forever and nothing is issued.
- `prog_we` in any other state is ignored and the memory is unchanged.
- If `start` and `prog_we` are asserted together in IDLE or HALTED:
  - the write is performed;
  - the first FETCH, one cycle later, reads the updated memory.
- `start` while running is ignored.
- The memory contents are not reset.

## Timing

- Reset values:
  - state IDLE;
  - `pc` 0;
  - `issue_valid` 0;
  - `instruction`, `data_in_a`, `data_in_b` all 0x00;
  - `halted` 0.
- Reset asserted mid-operation:
  - takes effect immediately (asynchronous), and `issue_valid` drops without a handshake;
  - on release, the block waits in IDLE for `start`.
- The memory read is synchronous, with 1-cycle latency.
- Minimum issue spacing is 3 cycles (FETCH, DECODE, ISSUE) with `issue_ready` tied high.
- `start` seen in cycle N → FETCH in cycle N+1 → `issue_valid` is high in cycle N+3.
- Each JMP adds 2 cycles; there is no issue bubble beyond that.
- Handshake: transfer happens on a rising edge where `issue_valid` and `issue_ready` are both 1.
  - `issue_valid` never drops before a transfer, except on reset.
  - `issue_ready` may be high before `issue_valid`.
- All outputs come from registers. There are no combinational paths from inputs to outputs.

## Structure

- `cpu_pkg` is shared with `CPU`. It holds:
  - opcode constants OP_AND = 8'h00, OP_OR = 8'h01, OP_ADD = 8'h02, OP_SUB = 8'h03, OP_LD = 8'h04, OP_STORE = 8'h05, OP_JMP = 8'h06, OP_HALT = 8'hFF;
  - the fetch-state enum (IDLE, FETCH, DECODE, ISSUE, HALTED);
  - the field positions of the 24-bit program word.
- Sub-module `cpu_prog_mem`:
  - 2^ADDR_W × 24 RAM;
  - one synchronous write port and one synchronous read port;
  - no reset.
- The top level contains the FSM, the PC and the output registers.

## Test plan

- Reset and idle: hold `reset` = 0, pulse `start` → all outputs stay at reset values; `halted` = 0.
- Straight-line program:
  - Program: [0x02,0x05,0x03], [0x03,0x0F,0x01], [0xFF,0,0]. `issue_ready` = 1, `start` pulse.
  - Required: two issues, {02,05,03} then {03,0F,01}, issued 3 cycles apart.
  - Then `halted` = 1 with `pc` = 2.
- Backpressure: `issue_ready` = 0 for 5 cycles during the first issue → outputs and `pc` are stable throughout. Exactly one transfer occurs when ready rises.
- Jump:
  - Program: addr0 [0x06,0x03,0], addr3 [0x00,0xCC,0xAA], addr4 HALT.
  - Required: the first issue is {00,CC,AA}, arriving 5 cycles after `start`. The JMP never appears on the outputs.
- Wrap:
  - ADDR_W = 2, all four words ADD, ready = 1.
  - Required: `pc` sequence is 0,1,2,3,0,…; issues continue indefinitely.
- Reset mid-issue and program-write lockout:
  - `prog_we` to addr1 while in ISSUE → addr1 is unchanged on re-read.
  - `reset` = 0 during ISSUE → `issue_valid` = 0 within the same cycle. After release, the state is IDLE.
